// File: rtl/div_unit.sv
// div_unit -- sequential signed divider (MIPS div semantics).
//   Restoring shift-subtract on operand magnitudes (WIDTH iterations),
//   then one sign-fix cycle. Quotient goes to lo and remainder to hi.
//   Quotient truncates toward zero. Remainder takes the dividend's sign.
// Ports:
//   clk, reset (async active-low)
//   div_start, dividend, divisor : request, sampled only in IDLE
//   hi, lo                       : remainder / quotient, held between divides
//   busy                         : high while a divide is in flight
//   done                         : 1-cycle pulse when hi/lo were just updated
//   div_zero                     : 1-cycle pulse on a zero-divisor request
// Optional build macro DIV_EARLY_OUT_EN: when |dividend| < |divisor| the
//   result (lo=0, hi=dividend) is written on the start edge itself.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             div_start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] q, q_n;
  logic [WIDTH-1:0] r, r_n;   // partial remainder, always < M so WIDTH bits suffice
  logic [WIDTH:0]   m, m_n;   // |divisor| held unsigned (can be 2^(WIDTH-1))
  logic [CW-1:0]    cnt, cnt_n;
  logic             sign_q, sign_q_n, sign_r, sign_r_n;
  logic [WIDTH-1:0] hi_n, lo_n;
  logic             busy_n, done_n, div_zero_n;

  // operand magnitudes; -(-2^(WIDTH-1)) wraps to the correct unsigned value
  logic [WIDTH-1:0] abs_a, abs_b;
  assign abs_a = dividend[WIDTH-1] ? -dividend : dividend;
  assign abs_b = divisor[WIDTH-1]  ? -divisor  : divisor;

  // one restoring step: shift {R,Q} left, trial-subtract M
  logic [WIDTH:0]   r_sh;
  logic             ge;
  logic [WIDTH-1:0] diff;
  assign r_sh = {r, q[WIDTH-1]};
  assign ge   = (r_sh >= m);
  // true difference is < M <= 2^WIDTH, so the low WIDTH bits are exact
  assign diff = r_sh[WIDTH-1:0] - m[WIDTH-1:0];

  always_comb begin
    state_n    = state;
    q_n        = q;
    r_n        = r;
    m_n        = m;
    cnt_n      = cnt;
    sign_q_n   = sign_q;
    sign_r_n   = sign_r;
    hi_n       = hi;
    lo_n       = lo;
    busy_n     = busy;
    done_n     = 1'b0;
    div_zero_n = 1'b0;
    case (state)
      IDLE: begin
        if (div_start) begin
          if (divisor == '0) begin
            div_zero_n = 1'b1;
            done_n     = 1'b1;
          end
`ifdef DIV_EARLY_OUT_EN
          else if (abs_a < abs_b) begin
            lo_n   = '0;
            hi_n   = dividend;
            done_n = 1'b1;
          end
`endif
          else begin
            q_n      = abs_a;
            m_n      = {1'b0, abs_b};
            r_n      = '0;
            cnt_n    = CW'(WIDTH);
            sign_q_n = dividend[WIDTH-1] ^ divisor[WIDTH-1];
            sign_r_n = dividend[WIDTH-1];
            busy_n   = 1'b1;
            state_n  = CALC;
          end
        end
      end
      CALC: begin
        if (ge) begin
          r_n = diff;
          q_n = {q[WIDTH-2:0], 1'b1};
        end else begin
          r_n = r_sh[WIDTH-1:0];
          q_n = {q[WIDTH-2:0], 1'b0};
        end
        cnt_n = cnt - 1'b1;
        if (cnt == CW'(1)) state_n = FIX;
      end
      FIX: begin
        lo_n    = sign_q ? -q : q;
        hi_n    = sign_r ? -r : r;
        done_n  = 1'b1;
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      q        <= '0;
      r        <= '0;
      m        <= '0;
      cnt      <= '0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      state    <= state_n;
      q        <= q_n;
      r        <= r_n;
      m        <= m_n;
      cnt      <= cnt_n;
      sign_q   <= sign_q_n;
      sign_r   <= sign_r_n;
      hi       <= hi_n;
      lo       <= lo_n;
      busy     <= busy_n;
      done     <= done_n;
      div_zero <= div_zero_n;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit -- directed self-checking bench for div_unit (WIDTH=32).
// Expected results are hand-computed constants. Build with
// +define+DIV_EARLY_OUT_EN to check the early-out latency instead.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        div_start;
  logic [31:0] dividend, divisor;
  logic [31:0] hi, lo;
  logic        busy, done, div_zero;

  int checks   = 0;
  int failures = 0;
  int edges, bcnt;
  logic saw_busy;

  div_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .div_start(div_start),
    .dividend(dividend), .divisor(divisor),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the request already driven. Returns the number
  // of edges after E0 until done is seen, and the number of busy cycles.
  task automatic wait_done(output int n_edges, output int n_busy);
    int n;
    n = 0;
    n_busy = 0;
    n_edges = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      n++;
      if (n == 1) div_start = 1'b0;
      if (busy) n_busy++;
      if (done) begin
        n_edges = n - 1;
        break;
      end
    end
    if (n_edges < 0) chk("timeout", 32'd0, 32'd1);
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    dividend  = a;
    divisor   = b;
    div_start = 1'b1;
  endtask

  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_lo, input logic [31:0] exp_hi);
    issue(a, b);
    wait_done(edges, bcnt);
    chk({tag, "_lo"}, lo, exp_lo);
    chk({tag, "_hi"}, hi, exp_hi);
    chk({tag, "_dz"}, {31'd0, div_zero}, 32'd0);
    @(negedge clk);
    chk({tag, "_pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    reset = 1'b0; div_start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(negedge clk);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_flags", {29'd0, busy, done, div_zero}, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // 7 / 2 with latency and busy-width checks
    run_div("p7d2", 32'd7, 32'd2, 32'd3, 32'd1);
    chk("p7d2_edges", edges, 32'd33);
    chk("p7d2_busy", bcnt, 32'd33);

    run_div("m7d2", 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF);
    run_div("p7dm2", 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1);
    run_div("m8dm3", 32'hFFFFFFF8, 32'hFFFFFFFD, 32'd2, 32'hFFFFFFFE);
    run_div("minm1", 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0);

    // divide by zero: flag pulse, results kept, never busy
    issue(32'd100, 32'd0);
    saw_busy = 1'b0;
    @(negedge clk);
    div_start = 1'b0;
    saw_busy |= busy;
    chk("dz_flag", {30'd0, done, div_zero}, 32'd3);
    chk("dz_lo", lo, 32'h80000000);
    chk("dz_hi", hi, 32'd0);
    @(negedge clk);
    saw_busy |= busy;
    chk("dz_pulse", {30'd0, done, div_zero}, 32'd0);
    chk("dz_busy", {31'd0, saw_busy}, 32'd0);

    // 1000 / 7 with an ignored start while busy, then back-to-back 9 / 3
    issue(32'd1000, 32'd7);
    @(negedge clk);
    div_start = 1'b0;
    repeat (9) @(negedge clk);
    issue(32'd5, 32'd1);
    wait_done(edges, bcnt);
    chk("ign_lo", lo, 32'd142);
    chk("ign_hi", hi, 32'd6);
    issue(32'd9, 32'd3);           // start in the done cycle
    wait_done(edges, bcnt);
    chk("b2b_edges", edges, 32'd33);
    chk("b2b_lo", lo, 32'd3);
    chk("b2b_hi", hi, 32'd0);

    // reset mid-divide aborts with no result
    issue(32'h7FFFFFFF, 32'd3);
    @(negedge clk);
    div_start = 1'b0;
    repeat (14) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort_lo", lo, 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    saw_busy = 1'b0;
    repeat (3) begin
      @(negedge clk);
      saw_busy |= done;
    end
    chk("abort_done", {31'd0, saw_busy}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    run_div("p12d5", 32'd12, 32'd5, 32'd2, 32'd2);

    // small dividend: early-out path when enabled, full path otherwise
    run_div("p3d10", 32'd3, 32'd10, 32'd0, 32'd3);
`ifdef DIV_EARLY_OUT_EN
    chk("p3d10_edges", edges, 32'd0);
    chk("p3d10_busy", bcnt, 32'd0);
`else
    chk("p3d10_edges", edges, 32'd33);
    chk("p3d10_busy", bcnt, 32'd33);
`endif
    run_div("m3d10", 32'hFFFFFFFD, 32'd10, 32'd0, 32'hFFFFFFFD);
    run_div("z_d5", 32'd0, 32'd5, 32'd0, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
